// File: rtl/inst_fetch_queue.sv
// Fetch stage: issues instruction-pair reads for the current PC and buffers the returned
// pairs, with their PCs, in a small FIFO that feeds decode over valid/ready.
module inst_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IW    = 32,
  parameter int unsigned AW    = 8
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic [AW-1:0]            pc_in,
  output logic                     pc_stall,
  input  logic                     flush,
  output logic                     imem_req,
  output logic [AW-1:0]            imem_addr,
  input  logic [2*IW-1:0]          imem_rdata,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [IW-1:0]            dec_inst0,
  output logic [IW-1:0]            dec_inst1,
  output logic [AW-1:0]            dec_pc,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [2*IW-1:0] data_q [DEPTH];
  logic [AW-1:0]   pcs_q  [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            s1_valid;
  logic [AW-1:0]   s1_pc;
  logic            push;
  logic            pop;
  logic [PW+1:0]   occupancy;
  logic [2*IW-1:0] head_data;

  always_comb begin
    // Count the in-flight read so a returning pair always has a free slot.
    occupancy = {1'b0, q_count} + {{(PW + 1){1'b0}}, s1_valid};
    pc_stall  = ~flush & (occupancy >= (PW + 2)'(DEPTH));
    imem_req  = res & ~flush & ~pc_stall;
    imem_addr = pc_in;
    dec_valid = (q_count != '0);
    push      = s1_valid & ~flush;
    pop       = dec_valid & dec_ready & ~flush;
    head_data = data_q[rd_ptr];
    dec_inst0 = dec_valid ? head_data[IW-1:0]    : '0;
    dec_inst1 = dec_valid ? head_data[2*IW-1:IW] : '0;
    dec_pc    = dec_valid ? pcs_q[rd_ptr]        : '0;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      q_count  <= '0;
      s1_valid <= 1'b0;
      s1_pc    <= '0;
    end else begin
      s1_valid <= imem_req;
      if (imem_req) begin
        s1_pc <= pc_in;
      end
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        q_count <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push && !pop) begin
          q_count <= q_count + 1'b1;
        end else if (!push && pop) begin
          q_count <= q_count - 1'b1;
        end
      end
    end
  end

  // Storage needs no reset: entries are only observed when counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= imem_rdata;
      pcs_q[wr_ptr]  <= s1_pc;
    end
  end

endmodule
